mc_mdu: RTL and testbench

//  Iterative multiply/divide unit with HI/LO result registers for the multi-cycle CPU.

---
 rtl/mc_mdu_pkg.sv | 24 ++
 rtl/mc_mdu_if.sv | 28 ++
 rtl/mc_mdu_step.sv | 36 +++
 rtl/mc_mdu.sv | 161 ++++++++++++++++
 tb/tb_mc_mdu.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mc_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types, encodings and a width helper only).
// Backpressure: n/a.
package mc_mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    // Step counter width: must hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mc_mdu_if.sv
// Operand/result bundle between the CPU control path and the MDU.
// Latency: n/a (wiring only).
// Backpressure: requester must hold off start while busy is high; starts during busy are dropped.
interface mc_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mc_mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Latency: combinational; the caller registers the result each cycle.
// Backpressure: none.
module mc_mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;

    // Multiply: conditionally add multiplicand to the upper half, then shift the
    // whole accumulator right. Divide: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = shifted >= {1'b0, opnd};
        // Only taken when ge, where the true difference is below opnd and fits WIDTH bits.
        diff    = shifted[WIDTH-1:0] - opnd;
        if (div_mode) begin
            nxt_hi = ge ? diff : shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mc_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and MTHI/MTLO writes.
// Latency: WIDTH+1 cycles from accepted start to done pulse (WIDTH steps + sign fix-up).
// Backpressure: busy high while an op runs; start and MT writes during busy are ignored.
module mc_mdu
    import mc_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mc_mdu_if.slave    bus
);
    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mdu_state_e       state;
    mdu_state_e       nxt_state;
    logic             busy;
    logic             step_en;
    logic             fin;
    logic             accept;

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             is_signed;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             op_signed;
    logic             op_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] stp_hi;
    logic [WIDTH-1:0] stp_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign accept = bus.start && (state == S_IDLE);

    // Operand magnitudes; |INT_MIN| wraps to 2^(WIDTH-1), which is correct as unsigned.
    always_comb begin
        op_signed = bus.op[0];
        op_div    = bus.op[1];
        a_neg     = op_signed && bus.a[WIDTH-1];
        b_neg     = op_signed && bus.b[WIDTH-1];
        a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
        b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt_state;
    end

    // FSM next state: IDLE -> CALC x WIDTH -> FIX -> IDLE.
    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE:  if (bus.start)    nxt_state = S_CALC;
            S_CALC:  if (cnt == '0)    nxt_state = S_FIX;
            S_FIX:                     nxt_state = S_IDLE;
            default:                   nxt_state = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy    = (state != S_IDLE);
        step_en = (state == S_CALC);
        fin     = (state == S_FIX);
    end

    mc_mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .opnd     (opnd),
        .nxt_hi   (stp_hi),
        .nxt_lo   (stp_lo)
    );

    // Sign fix-up of the raw magnitude result; divide by zero forces lo to all ones
    // while hi (remainder = dividend) falls out of the normal path.
    always_comb begin
        prod   = {acc_hi, acc_lo};
        res_hi = acc_hi;
        res_lo = acc_lo;
        if (is_div) begin
            res_lo = (is_signed && neg_res) ? (~acc_lo + 1'b1) : acc_lo;
            res_hi = (is_signed && neg_rem) ? (~acc_hi + 1'b1) : acc_hi;
            if (div_zero) res_lo = '1;
        end else if (is_signed && neg_res) begin
            prod   = ~prod + 1'b1;
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    // Datapath: latch operands on accept, iterate during CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            acc_hi    <= '0;
            acc_lo    <= op_div ? a_mag : b_mag;
            opnd      <= op_div ? b_mag : a_mag;
            cnt       <= CNT_LAST;
            is_div    <= op_div;
            is_signed <= op_signed;
            neg_res   <= a_neg ^ b_neg;
            neg_rem   <= a_neg;
            div_zero  <= op_div && (bus.b == '0);
        end else if (step_en) begin
            acc_hi    <= stp_hi;
            acc_lo    <= stp_lo;
            cnt       <= cnt - 1'b1;
        end
    end

    // HI/LO registers: op completion has priority, MT writes only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fin;
            if (fin) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (!busy) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mc_mdu.sv
// Directed bench for mc_mdu at WIDTH=32: arithmetic, timing, MT writes, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_mc_mdu;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   lat;
    int   gaps;
    int   n;
    bit   seen;

    mc_mdu_if #(.WIDTH(W)) bus ();

    mc_mdu #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge after the start edge (count = start_n); returns the
    // number of negedges until done is seen and how many of them had busy low.
    task automatic wait_done(input int start_n, output int cnt, output int busy_gaps);
        cnt       = start_n;
        busy_gaps = 0;
        while (!bus.done && cnt < 100) begin
            if (!bus.busy) busy_gaps++;
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int l;
        int g;
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'h0BAD_F00D;
        wait_done(0, l, g);
        chk({tag, " lat"}, 64'(l), 64'd33);
        chk({tag, " busy"}, 64'(g), 64'd0);
        chk({tag, " hi"}, {32'd0, bus.hi}, {32'd0, ehi});
        chk({tag, " lo"}, {32'd0, bus.lo}, {32'd0, elo});
        chk({tag, " idle"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

        #12;
        chk("rst busy", {63'd0, bus.busy}, 64'd0);
        chk("rst done", {63'd0, bus.done}, 64'd0);
        chk("rst hi", {32'd0, bus.hi}, 64'd0);
        chk("rst lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // MTHI / MTLO while idle
        @(negedge clk); bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        @(negedge clk); bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'hABCD;
        chk("mthi hi", {32'd0, bus.hi}, 64'h1234);
        @(negedge clk); bus.lo_we = 1'b0;
        chk("mtlo lo", {32'd0, bus.lo}, 64'hABCD);
        chk("mtlo hi kept", {32'd0, bus.hi}, 64'h1234);
        @(negedge clk); bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h77;
        @(negedge clk); bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("mt both hi", {32'd0, bus.hi}, 64'h77);
        chk("mt both lo", {32'd0, bus.lo}, 64'h77);
        chk("mt busy", {63'd0, bus.busy}, 64'd0);
        chk("mt done", {63'd0, bus.done}, 64'd0);

        // Arithmetic vectors
        run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -3*7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 7/-2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu 7/0", 2'b10, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div -7/0", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("mult min*min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // MT write coinciding with an accepted start: visible, then overwritten
        @(negedge clk);
        bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
        bus.lo_we = 1'b1; bus.wdata = 32'hAA;
        @(negedge clk);
        bus.start = 1'b0; bus.lo_we = 1'b0;
        chk("mt+start lo", {32'd0, bus.lo}, 64'hAA);
        chk("mt+start busy", {63'd0, bus.busy}, 64'd1);
        wait_done(0, lat, gaps);
        chk("mt+start lat", 64'(lat), 64'd33);
        chk("mt+start res lo", {32'd0, bus.lo}, 64'd6);
        chk("mt+start res hi", {32'd0, bus.hi}, 64'd0);

        // Start and MT write during busy are ignored
        @(negedge clk);
        bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        repeat (5) begin @(negedge clk); n++; end
        bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd2; bus.start = 1'b1;
        @(negedge clk); n++;
        bus.start = 1'b0; bus.hi_we = 1'b1; bus.wdata = 32'h55;
        @(negedge clk); n++;
        bus.hi_we = 1'b0;
        chk("busy mthi ignored", {32'd0, bus.hi}, 64'd0);
        wait_done(n, lat, gaps);
        chk("busy ign lat", 64'(lat), 64'd33);
        chk("busy ign gaps", 64'(gaps), 64'd0);
        chk("divu 100/7 hi", {32'd0, bus.hi}, 64'd2);
        chk("divu 100/7 lo", {32'd0, bus.lo}, 64'd14);

        // Start in the done cycle is accepted
        bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done-cycle start busy", {63'd0, bus.busy}, 64'd1);
        chk("done-cycle done low", {63'd0, bus.done}, 64'd0);
        wait_done(0, lat, gaps);
        chk("done-cycle lat", 64'(lat), 64'd33);
        chk("multu 3*5 lo", {32'd0, bus.lo}, 64'd15);
        chk("multu 3*5 hi", {32'd0, bus.hi}, 64'd0);

        // Asynchronous reset mid-operation aborts without a result
        @(negedge clk);
        bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd6; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy", {63'd0, bus.busy}, 64'd0);
        chk("abort hi", {32'd0, bus.hi}, 64'd0);
        chk("abort lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("abort no done", {63'd0, seen}, 64'd0);
        run_op("mult 5*-6", 2'b01, 32'd5, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFE2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
